// File: rtl/nexusv_bus_arbiter.sv
// Two-master round-robin arbiter for the NexusV peripheral bus.
// It registers each request toward the slave, returns a one-cycle response pulse and aborts a request that the slave never answers.
module nexusv_bus_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_write,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_write,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic        s_write,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic        owner,
    output logic        busy,
    output logic [7:0]  timeout_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic        WDOG_EN   = (TIMEOUT != 0);
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT) - 32'd1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    state_t      state_r;
    logic        owner_r;
    logic        last_owner_r;
    logic [31:0] wdog_r;
    logic [7:0]  timeout_cnt_r;
    logic        s_valid_r;
    logic [31:0] s_addr_r;
    logic [31:0] s_wdata_r;
    logic        s_write_r;
    logic        busy_r;
    logic        m0_ready_r;
    logic [31:0] m0_rdata_r;
    logic        m0_err_r;
    logic        m1_ready_r;
    logic [31:0] m1_rdata_r;
    logic        m1_err_r;

    logic        req_any_s;
    logic        grant_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        sel_write_s;
    logic        abort_s;

    // Grant selection: a tie goes to the master that did not own the last transaction.
    always_comb begin
        req_any_s = m0_valid | m1_valid;
        grant_s   = 1'b0;
        if (m0_valid && m1_valid) begin
            grant_s = ~last_owner_r;
        end else if (m1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
            sel_write_s = m1_write;
        end else begin
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
            sel_write_s = m0_write;
        end
        abort_s = WDOG_EN && (wdog_r == WDOG_LAST);
    end

    // Arbitration FSM with every output held in a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            owner_r       <= 1'b0;
            last_owner_r  <= 1'b1;
            wdog_r        <= 32'd0;
            timeout_cnt_r <= 8'd0;
            s_valid_r     <= 1'b0;
            s_addr_r      <= 32'd0;
            s_wdata_r     <= 32'd0;
            s_write_r     <= 1'b0;
            busy_r        <= 1'b0;
            m0_ready_r    <= 1'b0;
            m0_rdata_r    <= 32'd0;
            m0_err_r      <= 1'b0;
            m1_ready_r    <= 1'b0;
            m1_rdata_r    <= 32'd0;
            m1_err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        owner_r      <= grant_s;
                        last_owner_r <= grant_s;
                        s_addr_r     <= sel_addr_s;
                        s_wdata_r    <= sel_wdata_s;
                        s_write_r    <= sel_write_s;
                        s_valid_r    <= 1'b1;
                        busy_r       <= 1'b1;
                        wdog_r       <= 32'd0;
                        state_r      <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // A slave answer on the final watchdog cycle still counts as a normal completion.
                    if (s_ready || abort_s) begin
                        s_valid_r <= 1'b0;
                        state_r   <= ST_RESP;
                        if (owner_r) begin
                            m1_ready_r <= 1'b1;
                            m1_rdata_r <= s_ready ? s_rdata : 32'd0;
                            m1_err_r   <= ~s_ready;
                        end else begin
                            m0_ready_r <= 1'b1;
                            m0_rdata_r <= s_ready ? s_rdata : 32'd0;
                            m0_err_r   <= ~s_ready;
                        end
                        if (!s_ready) begin
                            timeout_cnt_r <= sat_inc8(timeout_cnt_r);
                        end else begin
                            timeout_cnt_r <= timeout_cnt_r;
                        end
                    end else begin
                        wdog_r <= wdog_r + 32'd1;
                    end
                end
                ST_RESP: begin
                    m0_ready_r <= 1'b0;
                    m0_rdata_r <= 32'd0;
                    m0_err_r   <= 1'b0;
                    m1_ready_r <= 1'b0;
                    m1_rdata_r <= 32'd0;
                    m1_err_r   <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    s_valid_r  <= 1'b0;
                    busy_r     <= 1'b0;
                    m0_ready_r <= 1'b0;
                    m1_ready_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_ready    = m0_ready_r;
    assign m0_rdata    = m0_rdata_r;
    assign m0_err      = m0_err_r;
    assign m1_ready    = m1_ready_r;
    assign m1_rdata    = m1_rdata_r;
    assign m1_err      = m1_err_r;
    assign s_valid     = s_valid_r;
    assign s_addr      = s_addr_r;
    assign s_wdata     = s_wdata_r;
    assign s_write     = s_write_r;
    assign owner       = owner_r;
    assign busy        = busy_r;
    assign timeout_cnt = timeout_cnt_r;

endmodule

// File: tb/tb_nexusv_bus_arbiter.sv
// Directed bench for nexusv_bus_arbiter with a short watchdog (TIMEOUT=4).
module tb_nexusv_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_write, m1_write;
    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_write, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        owner, busy;
    logic [7:0]  timeout_cnt;

    int n_cmp = 0;
    int n_err = 0;

    nexusv_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_write(s_write),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .owner(owner), .busy(busy), .timeout_cnt(timeout_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_own;
        rst_n = 1'b0;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_addr = 32'd0; m1_addr = 32'd0; m0_wdata = 32'd0; m1_wdata = 32'd0;
        m0_write = 1'b0; m1_write = 1'b0;
        s_ready = 1'b0; s_rdata = 32'd0;
        tick();
        tick();
        chk1("rst_s_valid", s_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chk1("rst_m0_ready", m0_ready, 1'b0);
        chk1("rst_m1_ready", m1_ready, 1'b0);
        chk32("rst_s_addr", s_addr, 32'd0);
        chk8("rst_tcnt", timeout_cnt, 8'd0);
        rst_n = 1'b1;
        tick();

        // Contention right after reset: 0,1,0,1 with the slave always ready.
        m0_valid = 1'b1; m0_addr = 32'h0000_A000;
        m1_valid = 1'b1; m1_addr = 32'h0000_B000;
        s_ready = 1'b1; s_rdata = 32'h0000_0077;
        for (int g = 0; g < 4; g++) begin
            exp_own = g[0];
            tick();
            chk1("rr_owner", owner, exp_own);
            chk1("rr_s_valid", s_valid, 1'b1);
            chk32("rr_s_addr", s_addr, exp_own ? 32'h0000_B000 : 32'h0000_A000);
            tick();
            chk1("rr_m0_ready", m0_ready, ~exp_own);
            chk1("rr_m1_ready", m1_ready, exp_own);
            chk1("rr_busy_resp", busy, 1'b1);
            tick();
            chk1("rr_gap_s_valid", s_valid, 1'b0);
            chk1("rr_gap_busy", busy, 1'b0);
            chk1("rr_gap_m0_ready", m0_ready, 1'b0);
            chk1("rr_gap_m1_ready", m1_ready, 1'b0);
        end
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        tick();

        // Single read from master 0, slave answers on the 3rd REQ cycle.
        m0_valid = 1'b1; m0_addr = 32'h8000_0010; m0_write = 1'b0;
        tick();
        chk1("rd_s_valid1", s_valid, 1'b1);
        chk32("rd_s_addr", s_addr, 32'h8000_0010);
        chk1("rd_owner", owner, 1'b0);
        tick();
        chk1("rd_s_valid2", s_valid, 1'b1);
        chk1("rd_m0_ready_early", m0_ready, 1'b0);
        tick();
        chk1("rd_s_valid3", s_valid, 1'b1);
        s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        tick();
        chk1("rd_s_valid_resp", s_valid, 1'b0);
        chk1("rd_m0_ready", m0_ready, 1'b1);
        chk32("rd_m0_rdata", m0_rdata, 32'hCAFE_F00D);
        chk1("rd_m0_err", m0_err, 1'b0);
        chk1("rd_m1_ready", m1_ready, 1'b0);
        chk32("rd_m1_rdata", m1_rdata, 32'd0);
        m0_valid = 1'b0;
        tick();
        s_ready = 1'b0;
        chk1("rd_m0_ready_after", m0_ready, 1'b0);
        chk32("rd_m0_rdata_after", m0_rdata, 32'd0);

        // Write from master 1.
        m1_valid = 1'b1; m1_addr = 32'h8000_0100; m1_wdata = 32'h1234_5678; m1_write = 1'b1;
        tick();
        chk1("wr_owner", owner, 1'b1);
        chk32("wr_s_addr", s_addr, 32'h8000_0100);
        chk32("wr_s_wdata", s_wdata, 32'h1234_5678);
        chk1("wr_s_write", s_write, 1'b1);
        tick();
        chk32("wr_s_addr_hold", s_addr, 32'h8000_0100);
        chk32("wr_s_wdata_hold", s_wdata, 32'h1234_5678);
        s_ready = 1'b1; s_rdata = 32'd0;
        tick();
        chk1("wr_m1_ready", m1_ready, 1'b1);
        chk1("wr_m1_err", m1_err, 1'b0);
        chk1("wr_m0_ready", m0_ready, 1'b0);
        m1_valid = 1'b0; m1_write = 1'b0; s_ready = 1'b0;
        tick();
        chk1("wr_m1_ready_after", m1_ready, 1'b0);

        // Timeout: the slave never answers.
        m0_valid = 1'b1; m0_addr = 32'h8000_0200; s_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk1("to_s_valid", s_valid, 1'b1);
        end
        tick();
        chk1("to_s_valid_resp", s_valid, 1'b0);
        chk1("to_m0_ready", m0_ready, 1'b1);
        chk1("to_m0_err", m0_err, 1'b1);
        chk32("to_m0_rdata", m0_rdata, 32'd0);
        chk8("to_tcnt", timeout_cnt, 8'd1);
        m0_valid = 1'b0;
        tick();
        chk1("to_m0_err_after", m0_err, 1'b0);

        // Slave answers on the last REQ cycle: normal completion wins.
        m0_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk1("lr_s_valid4", s_valid, 1'b1);
        s_ready = 1'b1; s_rdata = 32'h55AA_55AA;
        tick();
        chk1("lr_m0_ready", m0_ready, 1'b1);
        chk1("lr_m0_err", m0_err, 1'b0);
        chk32("lr_m0_rdata", m0_rdata, 32'h55AA_55AA);
        chk8("lr_tcnt", timeout_cnt, 8'd1);
        m0_valid = 1'b0;
        tick();

        // Stray slave ready in IDLE.
        tick();
        chk1("stray_busy", busy, 1'b0);
        chk1("stray_s_valid", s_valid, 1'b0);
        chk1("stray_m0_ready", m0_ready, 1'b0);
        chk1("stray_m1_ready", m1_ready, 1'b0);
        s_ready = 1'b0;

        // Reset in the middle of a master-1 transaction.
        m1_valid = 1'b1; m1_addr = 32'h8000_0300;
        tick();
        chk1("mr_owner_pre", owner, 1'b1);
        chk1("mr_s_valid_pre", s_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("mr_s_valid", s_valid, 1'b0);
        chk1("mr_busy", busy, 1'b0);
        chk1("mr_owner", owner, 1'b0);
        chk32("mr_s_addr", s_addr, 32'd0);
        chk8("mr_tcnt", timeout_cnt, 8'd0);
        m0_valid = 1'b1; m0_addr = 32'h8000_0400;
        tick();
        chk1("mr_m1_ready_held", m1_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        chk1("mr_tie_owner", owner, 1'b0);
        chk32("mr_tie_addr", s_addr, 32'h8000_0400);
        chk1("mr_m1_ready", m1_ready, 1'b0);
        s_ready = 1'b1; s_rdata = 32'h0000_0ABC;
        tick();
        chk1("mr_m0_ready", m0_ready, 1'b1);
        chk32("mr_m0_rdata", m0_rdata, 32'h0000_0ABC);
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nexusv_bus_arbiter.md
# nexusv_bus_arbiter

Two-master, one-slave arbiter for the NexusV external peripheral bus. It shares the downstream APB-side port between master 0 (the core's `bus_*` port) and master 1 (a secondary requester such as DMA or a debug port). Arbitration is round-robin. The arbiter registers each transaction toward the slave and returns a one-cycle response pulse to the owning master. A watchdog aborts transactions the slave never acknowledges.

## Interface
- `TIMEOUT`, default 64: cycles in REQ before abort; 0 disables the watchdog.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_valid`, `m1_valid`  in  1  request; held high with addr/wdata/write stable until the matching `mX_ready`.
- `m0_addr`, `m1_addr`  in  32  target address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_write`, `m1_write`  in  1  1 = write, 0 = read.
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32  read data; valid while `mX_ready`=1, 0 otherwise.
- `m0_err`, `m1_err`  out  1  high with `mX_ready` when the transaction timed out.
- `s_valid`  out  1  registered request to slave.
- `s_addr`, `s_wdata`  out  32  registered address and write data.
- `s_write`  out  1  registered direction.
- `s_rdata`  in  32  slave read data; sampled when `s_ready`=1.
- `s_ready`  in  1  slave completion; only meaningful in REQ.
- `owner`  out  1  master of the current or last transaction.
- `busy`  out  1  high in REQ or RESP.
- `timeout_cnt`  out  8  saturating count of aborted transactions.

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**
  - Sample `m0_valid` and `m1_valid`.
  - One requester: grant it.
  - Both requesting: grant the master not equal to `last_owner`.
  - On grant: latch that master's addr/wdata/write into `s_*`, set `owner`/`last_owner`, clear the watchdog counter, go to REQ.
  - No request: stay in IDLE.
- **REQ**
  - `s_valid`=1; `s_*` held constant.
  - `s_ready`=1: latch `s_rdata` into the response register, clear the error flag, go to RESP.
  - Otherwise the counter increments. If `TIMEOUT`≠0 and counter == `TIMEOUT`-1: set the error flag, load response 32'h0, increment `timeout_cnt` (saturates at 255), go to RESP.
- **RESP** (exactly one cycle)
  - `s_valid`=0.
  - `m[owner]_ready`=1, `m[owner]_rdata`=response register, `m[owner]_err`=error flag.
  - The non-owner's ready/rdata/err are 0.
  - Next state is always IDLE. Requests are not sampled in RESP, so the owner's still-high valid cannot re-issue.
- The response register, error flag and `last_owner` are registered; `mX_ready`/`mX_rdata`/`mX_err` are decoded from state and owner.
- `s_ready` outside REQ is ignored.
- A master that drops valid during REQ violates protocol. The arbiter still completes the transaction and pulses ready.
- Writes are returned with `rdata` = latched `s_rdata` (slave-defined, normally 0).

## Timing
- **Reset values:** state IDLE, `s_valid`=0, `s_addr`/`s_wdata`=0, `s_write`=0, `owner`=0, `last_owner`=1 (master 0 wins the first tie), `busy`=0, all `mX_ready`/`mX_err`=0, `mX_rdata`=0, `timeout_cnt`=0, watchdog=0.
- **Reset mid-transaction:** asserting `rst_n` low forces all outputs to reset values immediately (asynchronous), with no response pulse. Release is synchronous to the next edge.
- **Latency:** valid sampled in IDLE at cycle N gives `s_valid`=1 in cycle N+1.
- If `s_ready` arrives in cycle N+1+k, `mX_ready` pulses in cycle N+2+k. Minimum request-to-ready is 2 cycles (k=0); total occupancy is 3 cycles including the IDLE sample.
- **Back-to-back:** after RESP, IDLE follows for at least one cycle, so the minimum spacing between grants is 3 cycles.
- **Timeout:** abort fires at the edge ending the `TIMEOUT`-th REQ cycle. With `TIMEOUT`=64, `s_valid` is high for exactly 64 cycles and err ready pulses in the 65th.
- `s_ready` on the final REQ cycle takes priority over the timeout: normal completion, no error.
- `busy`=1 in every REQ and RESP cycle.

## Test plan
- **Single read, master 0:** `m0_valid`=1, addr 0x8000_0010; slave `s_ready`=1 on its 3rd REQ cycle with `s_rdata`=0xCAFE_F00D. Expect `s_valid` high for 3 cycles, then `m0_ready`=1 for 1 cycle with `m0_rdata`=0xCAFE_F00D and `m0_err`=0; `m1_ready` stays 0.
- **Simultaneous requests after reset:** both valid in the same cycle. Expect master 0 granted first, master 1 next (IDLE gap of 1 cycle). Repeated contention alternates 0,1,0,1; `owner` tracks each grant.
- **Write, master 1:** addr 0x8000_0100, wdata 0x1234_5678, `write`=1. Expect `s_addr`/`s_wdata`/`s_write` to match and stay stable through REQ; `m1_ready` pulses once.
- **Timeout:** `TIMEOUT`=4, slave never ready. Expect `s_valid` high 4 cycles, then `m0_ready`=1, `m0_err`=1, `m0_rdata`=0, `timeout_cnt` 0→1. Also run `s_ready` on REQ cycle 4: expect `err`=0.
- **Reset mid-REQ:** drop `rst_n` during REQ. Expect `s_valid`=0 immediately; no ready pulse; after release the next request is granted normally with master 0 winning a tie.
- **Stray ready:** `s_ready`=1 in IDLE and in RESP. Expect no state change and no extra `mX_ready` pulse.
